telemetry_tx_sched: RTL and testbench



---
 rtl/telemetry_pkg.sv | 33 +++
 rtl/telemetry_tx_sched_tick_counter.sv | 36 +++
 rtl/telemetry_tx_sched.sv | 186 ++++++++++++++++++
 tb/tb_telemetry_tx_sched.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/telemetry_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | telemetry_pkg : shared framing constants and state types             |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package telemetry_pkg;

    localparam logic [7:0] HDR         = 8'hA5;
    localparam logic [7:0] TYPE_ALARM  = 8'h01;
    localparam logic [7:0] TYPE_DIST   = 8'h02;
    localparam logic [7:0] TYPE_MOTION = 8'h03;

    localparam logic [3:0] LEN_ALARM   = 4'd4;
    localparam logic [3:0] LEN_DIST    = 4'd11;
    localparam logic [3:0] LEN_MOTION  = 4'd6;

    localparam int MAX_LEN = 11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SRC_ALARM  = 2'd0,
        SRC_DIST   = 2'd1,
        SRC_MOTION = 2'd2
    } src_t;

endpackage
`default_nettype wire

// File: rtl/telemetry_tx_sched_tick_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tick_counter : counts 0..LEN-1 while enabled, wrap pulse on last     |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module tick_counter #(
    parameter int LEN = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic wrap_o
);

    localparam int              W    = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [W-1:0]    LAST = W'(LEN - 1);

    logic [W-1:0] cnt_q;

    // Dropping the enable parks the count at zero so the next run is a full interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en_i) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign wrap_o = en_i && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/telemetry_tx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | telemetry_tx_sched : arbitrates alarm/distance/motion frames onto    |
// |                      the shared UART transmitter                     |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
module telemetry_tx_sched
    import telemetry_pkg::*;
#(
    parameter int PERIOD   = 5_000_000,
    parameter int BYTE_GAP = 57_300
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic [7:0]  close_flag_i,
    input  logic [12:0] dist_f_i,
    input  logic [12:0] dist_b_i,
    input  logic [12:0] dist_l_i,
    input  logic [12:0] dist_r_i,
    input  logic [15:0] car_speed_i,
    input  logic [3:0]  state_ctrl_i,
    output logic [7:0]  tx_din_o,
    output logic        tx_vld_o,
    output logic        busy_o,
    output logic        frame_done_o
);

    state_t      state_q;
    src_t        sel_q;
    logic [7:0]  last_alarm_q;
    logic        pend_dist_q, pend_dist_d;
    logic        pend_motion_q, pend_motion_d;
    logic [3:0]  idx_q;
    logic [3:0]  len_q;
    logic [7:0]  frame_q [0:MAX_LEN-1];
    logic [7:0]  frame_d [0:MAX_LEN-1];
    logic [3:0]  len_d;
    logic [7:0]  chk;
    logic [7:0]  tx_din_q;
    logic        tx_vld_q;
    logic        frame_done_q;

    logic        period_tick;
    logic        gap_wrap;
    logic        alarm_req;
    logic [3:0]  next_idx;

    tick_counter #(.LEN(PERIOD)) u_period (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (en_i),
        .wrap_o (period_tick)
    );

    tick_counter #(.LEN(BYTE_GAP - 1)) u_gap (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (state_q == S_GAP),
        .wrap_o (gap_wrap)
    );

    assign alarm_req = (close_flag_i != last_alarm_q);
    assign next_idx  = idx_q + 4'd1;

    // A tick landing on the LOAD that clears the same flag keeps it pending.
    always_comb begin
        pend_dist_d   = (pend_dist_q && !(state_q == S_LOAD && sel_q == SRC_DIST))
                        || period_tick;
        pend_motion_d = (pend_motion_q && !(state_q == S_LOAD && sel_q == SRC_MOTION))
                        || period_tick;
    end

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            frame_d[i] = 8'h00;
        end
        len_d      = LEN_ALARM;
        chk        = 8'h00;
        frame_d[0] = HDR;
        case (sel_q)
            SRC_DIST: begin
                len_d       = LEN_DIST;
                frame_d[1]  = TYPE_DIST;
                frame_d[2]  = {3'b000, dist_f_i[12:8]};
                frame_d[3]  = dist_f_i[7:0];
                frame_d[4]  = {3'b000, dist_b_i[12:8]};
                frame_d[5]  = dist_b_i[7:0];
                frame_d[6]  = {3'b000, dist_l_i[12:8]};
                frame_d[7]  = dist_l_i[7:0];
                frame_d[8]  = {3'b000, dist_r_i[12:8]};
                frame_d[9]  = dist_r_i[7:0];
            end
            SRC_MOTION: begin
                len_d       = LEN_MOTION;
                frame_d[1]  = TYPE_MOTION;
                frame_d[2]  = car_speed_i[15:8];
                frame_d[3]  = car_speed_i[7:0];
                frame_d[4]  = {4'b0000, state_ctrl_i};
            end
            default: begin
                frame_d[1]  = TYPE_ALARM;
                frame_d[2]  = close_flag_i;
            end
        endcase
        // Unused slots are still zero here, so summing every slot past the header is exact.
        for (int i = 1; i < MAX_LEN; i++) begin
            chk = chk + frame_d[i];
        end
        frame_d[len_d - 4'd1] = chk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            sel_q         <= SRC_ALARM;
            last_alarm_q  <= 8'h00;
            pend_dist_q   <= 1'b0;
            pend_motion_q <= 1'b0;
            idx_q         <= 4'd0;
            len_q         <= 4'd0;
            tx_din_q      <= 8'h00;
            tx_vld_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                frame_q[i] <= 8'h00;
            end
        end else begin
            pend_dist_q   <= pend_dist_d;
            pend_motion_q <= pend_motion_d;
            tx_vld_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (alarm_req) begin
                        sel_q   <= SRC_ALARM;
                        state_q <= S_LOAD;
                    end else if (pend_dist_q) begin
                        sel_q   <= SRC_DIST;
                        state_q <= S_LOAD;
                    end else if (pend_motion_q) begin
                        sel_q   <= SRC_MOTION;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    frame_q  <= frame_d;
                    len_q    <= len_d;
                    idx_q    <= 4'd0;
                    if (sel_q == SRC_ALARM) begin
                        last_alarm_q <= close_flag_i;
                    end
                    tx_vld_q <= 1'b1;
                    tx_din_q <= HDR;
                    state_q  <= S_SEND;
                end
                S_SEND: begin
                    state_q <= S_GAP;
                end
                S_GAP: begin
                    if (gap_wrap) begin
                        if (idx_q < len_q - 4'd1) begin
                            idx_q    <= next_idx;
                            tx_vld_q <= 1'b1;
                            tx_din_q <= frame_q[next_idx];
                            state_q  <= S_SEND;
                        end else begin
                            frame_done_q <= 1'b1;
                            state_q      <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_din_o     = tx_din_q;
    assign tx_vld_o     = tx_vld_q;
    assign busy_o       = (state_q != S_IDLE);
    assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_telemetry_tx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_telemetry_tx_sched : directed + randomized frame checks against   |
// |                         a byte-level frame model                     |
// | Revision              : 1.0                                          |
// +----------------------------------------------------------------------+
module tb_telemetry_tx_sched;

    localparam int PERIOD = 200;
    localparam int GAP    = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  close_flag = 8'h00;
    logic [12:0] df = '0, db = '0, dl = '0, dr = '0;
    logic [15:0] spd = '0;
    logic [3:0]  st = '0;
    logic [7:0]  tx_din;
    logic        tx_vld, busy, frame_done;

    telemetry_tx_sched #(.PERIOD(PERIOD), .BYTE_GAP(GAP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en),
        .close_flag_i (close_flag),
        .dist_f_i     (df),
        .dist_b_i     (db),
        .dist_l_i     (dl),
        .dist_r_i     (dr),
        .car_speed_i  (spd),
        .state_ctrl_i (st),
        .tx_din_o     (tx_din),
        .tx_vld_o     (tx_vld),
        .busy_o       (busy),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] rx_q[$];
    int         rx_c[$];
    int         done_c[$];
    logic [7:0] exp_q[$];
    logic [7:0] pl[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         first_cyc = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_vld) begin
                rx_q.push_back(tx_din);
                rx_c.push_back(cyc);
            end
            if (frame_done) done_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: header, type, payload, then the mod-256 sum of type+payload.
    task automatic emit(input logic [7:0] typ);
        int s;
        s = int'(typ);
        exp_q.push_back(8'hA5);
        exp_q.push_back(typ);
        foreach (pl[i]) begin
            exp_q.push_back(pl[i]);
            s += int'(pl[i]);
        end
        exp_q.push_back(8'(s % 256));
        pl.delete();
    endtask

    task automatic exp_alarm(input logic [7:0] v);
        pl.push_back(v);
        emit(8'h01);
    endtask

    task automatic exp_dist(input logic [12:0] f, input logic [12:0] b,
                            input logic [12:0] l, input logic [12:0] r);
        logic [12:0] d [4];
        d = '{f, b, l, r};
        foreach (d[i]) begin
            pl.push_back(8'(d[i] >> 8));
            pl.push_back(8'(d[i] & 13'h0FF));
        end
        emit(8'h02);
    endtask

    task automatic exp_motion(input logic [15:0] s, input logic [3:0] c);
        pl.push_back(8'(s / 256));
        pl.push_back(8'(s % 256));
        pl.push_back({4'h0, c});
        emit(8'h03);
    endtask

    task automatic check_frame(input string tag);
        int n, last;
        n = exp_q.size();
        last = 0;
        for (int i = 0; i < 4000 && rx_q.size() < n; i++) @(negedge clk);
        chk({tag, " arrived"}, 32'(rx_q.size() >= n), 32'd1);
        if (rx_q.size() >= n) begin
            for (int i = 0; i < n; i++) begin
                chk($sformatf("%s byte%0d", tag, i), 32'(rx_q[0]), 32'(exp_q[i]));
                if (i == 0) first_cyc = rx_c[0];
                else chk($sformatf("%s spacing%0d", tag, i), 32'(rx_c[0] - last), 32'(GAP));
                last = rx_c[0];
                void'(rx_q.pop_front());
                void'(rx_c.pop_front());
            end
            for (int i = 0; i < 3 * GAP && done_c.size() == 0; i++) @(negedge clk);
            chk({tag, " done seen"}, 32'(done_c.size() > 0), 32'd1);
            if (done_c.size() > 0) begin
                chk({tag, " done timing"}, 32'(done_c[0] - last), 32'(GAP));
                void'(done_c.pop_front());
            end
        end
        exp_q.delete();
    endtask

    task automatic tick_once();
        @(negedge clk) en = 1'b1;
        for (int i = 0; i < 3 * PERIOD && !busy; i++) @(negedge clk);
        chk("tick busy", 32'(busy), 32'd1);
        en = 1'b0;
    endtask

    task automatic rand_inputs();
        df  = 13'($urandom);
        db  = 13'($urandom);
        dl  = 13'($urandom);
        dr  = 13'($urandom);
        spd = 16'($urandom);
        st  = 4'($urandom);
    endtask

    int          drv, cnt;
    logic [7:0]  cur_cf, nv;
    logic [12:0] of, ob, ol, orr;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst tx_vld", 32'(tx_vld), 32'd0);
        chk("rst tx_din", 32'(tx_din), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;

        // Quiet with en=0 and no alarm change
        cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx_vld || busy) cnt++;
        end
        chk("idle quiet", 32'(cnt), 32'd0);

        // Single alarm frame and its latency
        @(negedge clk) close_flag = 8'h05;
        drv = cyc;
        exp_q = '{8'hA5, 8'h01, 8'h05, 8'h06};
        check_frame("alarm05");
        chk("alarm latency", 32'(first_cyc - drv), 32'd2);
        repeat (100) @(negedge clk);
        chk("no second frame", 32'(rx_q.size()), 32'd0);
        cur_cf = 8'h05;

        // Periodic frames with literal expectations
        df = 13'h0123; db = 13'h0001; dl = 13'h00FF; dr = 13'h1FFF;
        spd = 16'h3C3C; st = 4'h2;
        tick_once();
        exp_q = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h1F, 8'hFF, 8'h44};
        check_frame("dist fixed");
        exp_q = '{8'hA5, 8'h03, 8'h3C, 8'h3C, 8'h02, 8'h7D};
        check_frame("motion fixed");

        // Alarm change in the same cycle as the period tick
        @(negedge clk) en = 1'b1;
        repeat (PERIOD - 1) @(negedge clk);
        close_flag = 8'h80;
        repeat (3) @(negedge clk);
        en = 1'b0;
        cur_cf = 8'h80;
        exp_alarm(8'h80);
        check_frame("coinc alarm");
        exp_dist(df, db, dl, dr);
        check_frame("coinc dist");
        exp_motion(spd, st);
        check_frame("coinc motion");

        // Alarm and distance change during byte 4 of a DIST frame, MOTION pending
        rand_inputs();
        of = df; ob = db; ol = dl; orr = dr;
        tick_once();
        for (int i = 0; i < 1000 && rx_q.size() < 4; i++) @(negedge clk);
        nv = cur_cf ^ 8'h5A;
        close_flag = nv;
        df = ~of;
        exp_dist(of, ob, ol, orr);
        check_frame("mid dist");
        exp_alarm(nv);
        check_frame("mid alarm");
        exp_motion(spd, st);
        check_frame("mid motion");
        cur_cf = nv;

        // Randomized mix of alarm-only and periodic requests
        for (int k = 0; k < 6; k++) begin
            rand_inputs();
            if ($urandom_range(0, 1) == 0) begin
                nv = 8'($urandom);
                if (nv == cur_cf) nv = nv ^ 8'h01;
                @(negedge clk) close_flag = nv;
                cur_cf = nv;
                exp_alarm(nv);
                check_frame($sformatf("rnd%0d alarm", k));
            end else begin
                tick_once();
                exp_dist(df, db, dl, dr);
                check_frame($sformatf("rnd%0d dist", k));
                exp_motion(spd, st);
                check_frame($sformatf("rnd%0d motion", k));
            end
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        // Reset while byte 3 of a DIST frame is on the wire
        rand_inputs();
        tick_once();
        for (int i = 0; i < 1000 && rx_q.size() < 2; i++) @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_vld) break;
        end
        rst_n = 1'b0;
        close_flag = 8'h00;
        #1;
        chk("midrst tx_vld", 32'(tx_vld), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst tx_din", 32'(tx_din), 32'd0);
        repeat (3) @(negedge clk);
        rx_q.delete(); rx_c.delete(); done_c.delete();
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("post rst quiet", 32'(rx_q.size()), 32'd0);
        @(negedge clk) close_flag = 8'h3C;
        exp_q = '{8'hA5, 8'h01, 8'h3C, 8'h3D};
        check_frame("post rst alarm");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
